ripple_count_monitor: RTL and testbench

Downstream consumer of the 6-stage asynchronous JK ripple down-counter. It samples the counter's q outputs, which ripple and glitch, into the clk domain. It filters out transient ripple values and publishes each settled count with a one-cycle valid strobe. It also checks that every accepted step is a decrement by one, and counts 0 -> all-ones wrap-arounds.

---
 rtl/ripple_count_monitor.sv | 134 +++++++++++++
 tb/tb_ripple_count_monitor.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor: samples the free-running ripple down-counter into
// clk, rejects values that are still rippling, and publishes each settled
// count with a one-cycle strobe. Every accepted step is classified as a
// normal decrement, a 0 -> all-ones wrap, or an error.
//
// state | meaning
// ACQ   | waiting for the pipeline to refill and settle before the first accept
// TRACK | publishing settled changes and checking each one against the last value
module ripple_count_monitor #(
  parameter int WIDTH  = 6,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic [WIDTH-1:0]  cnt_in,
  output logic [WIDTH-1:0]  cnt_out,
  output logic              cnt_valid,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              step_err,
  output logic              err_sticky
);

  typedef enum logic {ACQ, TRACK} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  s1_q, s2_q, s3_q;
  logic [1:0]        fill_q, fill_d;
  logic [WIDTH-1:0]  cnt_out_q, cnt_out_d;
  logic              valid_q, valid_d;
  logic              wrap_q, wrap_d;
  logic              err_q, err_d;
  logic              sticky_q, sticky_d;
  logic [WRAP_W-1:0] wc_q, wc_d;
  logic              stable;
  logic [WIDTH-1:0]  cnt_dec;

  assign stable  = (s2_q == s3_q);
  assign cnt_dec = cnt_out_q - WIDTH'(1);

  // Synchronizer plus one extra stage: two equal samples in a row mean the ripple has settled.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= cnt_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // State, fill counter, published count and status registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= ACQ;
      fill_q    <= 2'd0;
      cnt_out_q <= '0;
      valid_q   <= 1'b0;
      wrap_q    <= 1'b0;
      err_q     <= 1'b0;
      sticky_q  <= 1'b0;
      wc_q      <= '0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      cnt_out_q <= cnt_out_d;
      valid_q   <= valid_d;
      wrap_q    <= wrap_d;
      err_q     <= err_d;
      sticky_q  <= sticky_d;
      wc_q      <= wc_d;
    end
  end

  // Next-state logic: acceptance, step classification and wrap counting.
  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    cnt_out_d = cnt_out_q;
    valid_d   = 1'b0;
    wrap_d    = 1'b0;
    err_d     = 1'b0;
    sticky_d  = sticky_q;
    wc_d      = wc_q;

    // fill keeps the pipeline contents from before enable (zeros after clr) from being accepted
    if (!en) begin
      fill_d = 2'd0;
    end else if (state_q == ACQ && fill_q != 2'd3) begin
      fill_d = fill_q + 2'd1;
    end

    case (state_q)
      ACQ: begin
        if (en && fill_q == 2'd3 && stable) begin
          cnt_out_d = s2_q;
          valid_d   = 1'b1;
          state_d   = TRACK;
        end
      end
      TRACK: begin
        if (!en) begin
          state_d = ACQ;
        end else if (stable && s2_q != cnt_out_q) begin
          cnt_out_d = s2_q;
          valid_d   = 1'b1;
          if (cnt_out_q != '0 && s2_q == cnt_dec) begin
            // ordinary decrement, nothing to flag
          end else if (cnt_out_q == '0 && s2_q == '1) begin
            wrap_d = 1'b1;
            if (wc_q != '1) begin
              wc_d = wc_q + WRAP_W'(1);
            end
          end else begin
            err_d    = 1'b1;
            sticky_d = 1'b1;
          end
        end
      end
      default: state_d = ACQ;
    endcase
  end

  assign cnt_out    = cnt_out_q;
  assign cnt_valid  = valid_q;
  assign wrap_pulse = wrap_q;
  assign step_err   = err_q;
  assign err_sticky = sticky_q;
  assign wrap_count = wc_q;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Bench for ripple_count_monitor: directed steps with a scoreboard of
// expected accepted counts; a second instance with a 2-bit wrap counter
// covers saturation.
module tb_ripple_count_monitor;

  logic       clk;
  logic       clr;
  logic       en;
  logic [5:0] cnt_in;

  logic [5:0] cnt_out;
  logic       cnt_valid, wrap_pulse, step_err, err_sticky;
  logic [7:0] wrap_count;

  logic [5:0] c2_out;
  logic       c2_valid, c2_wrap, c2_err, c2_sticky;
  logic [1:0] c2_wc;

  ripple_count_monitor #(.WIDTH(6), .WRAP_W(8)) dut (
    .clk(clk), .clr(clr), .en(en), .cnt_in(cnt_in),
    .cnt_out(cnt_out), .cnt_valid(cnt_valid), .wrap_pulse(wrap_pulse),
    .wrap_count(wrap_count), .step_err(step_err), .err_sticky(err_sticky)
  );

  ripple_count_monitor #(.WIDTH(6), .WRAP_W(2)) dut2 (
    .clk(clk), .clr(clr), .en(en), .cnt_in(cnt_in),
    .cnt_out(c2_out), .cnt_valid(c2_valid), .wrap_pulse(c2_wrap),
    .wrap_count(c2_wc), .step_err(c2_err), .err_sticky(c2_sticky)
  );

  typedef struct {
    logic [5:0] cnt;
    logic       wrap;
    logic       err;
    logic       sticky;
    logic [7:0] wc;
    logic [1:0] wc2;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_wrap = 0;

  logic [5:0] m_cnt;
  logic       m_sticky;
  logic [7:0] m_wc;
  logic [1:0] m_wc2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input logic [5:0] c, input logic w, input logic e);
    exp_t x;
    x.cnt = c; x.wrap = w; x.err = e;
    x.sticky = m_sticky; x.wc = m_wc; x.wc2 = m_wc2;
    sb.push_back(x);
  endtask

  task automatic model_reset();
    m_cnt = '0; m_sticky = 1'b0; m_wc = '0; m_wc2 = '0;
  endtask

  // Hold a new settled value long enough to be accepted; predict its classification.
  task automatic step(input logic [5:0] v);
    logic w, e;
    w = 1'b0; e = 1'b0;
    if (v != m_cnt) begin
      if (m_cnt != 6'd0 && v == m_cnt - 6'd1) begin
      end else if (m_cnt == 6'd0 && v == 6'd63) begin
        w = 1'b1;
        if (m_wc != 8'd255) m_wc = m_wc + 8'd1;
        if (m_wc2 != 2'd3) m_wc2 = m_wc2 + 2'd1;
      end else begin
        e = 1'b1;
        m_sticky = 1'b1;
      end
      push_exp(v, w, e);
      m_cnt = v;
    end
    cnt_in = v;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic wait_acq(input string tag);
    int first;
    first = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (cnt_valid && first == 0) first = k;
    end
    check(tag, first, 4);
  endtask

  // Drop enable for one edge, present a new value, and require acceptance on the 4th edge.
  task automatic reacquire(input logic [5:0] v, input string tag);
    en = 1'b0;
    @(posedge clk);
    #1;
    cnt_in = v;
    en = 1'b1;
    m_cnt = v;
    push_exp(v, 1'b0, 1'b0);
    wait_acq(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cnt_out"}, cnt_out, 0);
    check({tag, "_flags"}, {cnt_valid, wrap_pulse, step_err, err_sticky}, 0);
    check({tag, "_wrap_count"}, wrap_count, 0);
    check({tag, "_dut2"}, {c2_out, c2_valid, c2_wrap, c2_err, c2_sticky, c2_wc}, 0);
  endtask

  // Scoreboard consumer: each strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!clr) begin
      check("valid_match_dut2", c2_valid, cnt_valid);
      if (cnt_valid) begin
        n_valid++;
        if (wrap_pulse) n_wrap++;
        check("sb_expected_valid", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          exp_t x;
          x = sb.pop_front();
          check("sb_cnt_out", cnt_out, x.cnt);
          check("sb_wrap_pulse", wrap_pulse, x.wrap);
          check("sb_step_err", step_err, x.err);
          check("sb_err_sticky", err_sticky, x.sticky);
          check("sb_wrap_count", wrap_count, x.wc);
          check("sb_wrap_count_w2", c2_wc, x.wc2);
        end
      end else begin
        check("idle_pulses", {wrap_pulse, step_err}, 0);
      end
    end
  end

  initial begin
    int v0, w0;
    clr = 1'b1; en = 1'b0; cnt_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");

    // Acquisition from clr with 5 held
    cnt_in = 6'd5;
    en = 1'b1;
    m_cnt = 6'd5;
    push_exp(6'd5, 1'b0, 1'b0);
    #2 clr = 1'b0;
    wait_acq("acq_from_clr_edge");
    check("acq_cnt_out", cnt_out, 5);

    // Down sequence across the wrap
    step(6'd4);
    v0 = n_valid; w0 = n_wrap;
    step(6'd3); step(6'd2); step(6'd1); step(6'd0); step(6'd63); step(6'd62);
    check("down_valid_count", n_valid - v0, 6);
    check("down_wrap_count", n_wrap - w0, 1);
    check("down_wrap_count_reg", wrap_count, 1);
    check("down_sticky", err_sticky, 0);

    // Skipped step
    reacquire(6'd10, "reacq_10_edge");
    step(6'd7);
    check("skip_cnt_out", cnt_out, 7);
    step(6'd6); step(6'd5);
    check("skip_sticky_held", err_sticky, 1);
    check("skip_wrap_unchanged", wrap_count, 1);

    // One-cycle ripple glitch is ignored
    reacquire(6'd21, "reacq_21_edge");
    v0 = n_valid;
    cnt_in = 6'd16;
    @(posedge clk);
    #1;
    cnt_in = 6'd21;
    repeat (6) @(posedge clk);
    #1;
    check("glitch_no_valid", n_valid - v0, 0);
    check("glitch_cnt_out", cnt_out, 21);
    step(6'd20);
    check("after_glitch_cnt_out", cnt_out, 20);

    // Saturation of the 2-bit wrap counter, from a clean reset
    en = 1'b0;
    clr = 1'b1;
    #2;
    check_all_zero("clr_before_sat");
    clr = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      reacquire(6'd1, "sat_acq_edge");
      step(6'd0);
      step(6'd63);
    end
    check("sat_wrap_count_w2", c2_wc, 3);
    check("sat_wrap_count_w8", wrap_count, 5);

    // Re-acquire, then async clear between edges
    reacquire(6'd30, "reacq_30_edge");
    reacquire(6'd12, "reacq_12_edge");
    check("reacq_cnt_out", cnt_out, 12);
    step(6'd9);
    check("pre_clr_sticky", err_sticky, 1);
    en = 1'b0;
    @(posedge clk);
    #2;
    clr = 1'b1;
    #1;
    check_all_zero("async_clr");
    #1 clr = 1'b0;
    model_reset();
    repeat (6) @(posedge clk);
    #1;
    check("final_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
